// File: rtl/lane_unstripe_4a1_if.sv
// Ready/valid bundle for the 4:1 lane unstripe block.
// The slave side is the unstriper; the master side feeds it.
interface lane_unstripe_4a1_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_mask;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_lane;
    logic             out_last;

    modport master (
        output in_valid, in_mask,
        output in_data0, in_data1,
        output in_data2, in_data3,
        output out_ready,
        input  in_ready, out_valid,
        input  out_data, out_lane,
        input  out_last
    );

    modport slave (
        input  in_valid, in_mask,
        input  in_data0, in_data1,
        input  in_data2, in_data3,
        input  out_ready,
        output in_ready, out_valid,
        output out_data, out_lane,
        output out_last
    );
endinterface

// File: rtl/lane_unstripe_4a1.sv
// Captures a masked 4-lane word and emits one byte per beat,
// lowest lane first, with registered outputs and a word counter.
module lane_unstripe_4a1 #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 C,
    input  logic                 R,
    lane_unstripe_4a1_if.slave   bus,
    output logic [CNT_WIDTH-1:0] word_cnt
);
    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state, state_n;

    logic [3:0][WIDTH-1:0] hold, hold_n;
    logic [3:0]            rem, rem_n;
    logic                  rdy;
    logic                  accept;
    logic                  beat;
    logic                  last_hs;
    logic [1:0]            lane_n;
    logic                  vld_n;
    logic                  last_n;
    logic [WIDTH-1:0]      data_n;

    function automatic logic [1:0] low_idx(
        input logic [3:0] m
    );
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic one_hot(
        input logic [3:0] m
    );
        return (m != 4'd0) &&
               ((m & (m - 4'd1)) == 4'd0);
    endfunction

    always_comb begin
        beat    = bus.out_valid & bus.out_ready;
        last_hs = beat & bus.out_last;
        rdy     = ~R & ((state == IDLE) | last_hs);
        accept  = bus.in_valid & rdy;
        hold_n  = hold;
        rem_n   = rem;
        state_n = state;
        if (beat)
            rem_n = rem & ~(4'b0001 << bus.out_lane);
        // A new word may overwrite rem on the last-beat edge
        if (accept) begin
            hold_n = {bus.in_data3, bus.in_data2,
                      bus.in_data1, bus.in_data0};
            rem_n  = bus.in_mask;
        end
        unique case (state)
            IDLE: begin
                if (accept && bus.in_mask != 4'd0)
                    state_n = SEND;
            end
            SEND: begin
                if (last_hs) begin
                    if (accept && bus.in_mask != 4'd0)
                        state_n = SEND;
                    else
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        vld_n  = (rem_n != 4'd0);
        lane_n = vld_n ? low_idx(rem_n) : 2'd0;
        last_n = one_hot(rem_n);
        data_n = vld_n ? hold_n[lane_n] : '0;
    end

    assign bus.in_ready = rdy;

    always_ff @(posedge C) begin
        if (R) begin
            state         <= IDLE;
            rem           <= 4'd0;
            hold          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_lane  <= 2'd0;
            bus.out_last  <= 1'b0;
            word_cnt      <= '0;
        end else begin
            state         <= state_n;
            rem           <= rem_n;
            hold          <= hold_n;
            bus.out_valid <= vld_n;
            bus.out_data  <= data_n;
            bus.out_lane  <= lane_n;
            bus.out_last  <= last_n;
            if (last_hs)
                word_cnt <= word_cnt + 1'b1;
        end
    end
endmodule
